// File: rtl/ch_unit_pkg.sv
// Shared constants for the channel playback/capture units: FSM state codes
// and trigger-mode selectors.
package ch_unit_pkg;

  typedef logic [1:0] ch_state_t;

  localparam logic [1:0] ST_IDLE    = 2'd0;
  localparam logic [1:0] ST_ARMED   = 2'd1;
  localparam logic [1:0] ST_CAPTURE = 2'd2;
  localparam logic [1:0] ST_DONE    = 2'd3;

  localparam logic TRIG_IMMEDIATE = 1'b0;
  localparam logic TRIG_EDGE      = 1'b1;

endpackage

// File: rtl/pos_oneshot.sv
// Rising-edge one-shot for GPIO level strobes: pulse is high for the single
// cycle in which level is high and was low on the previous clock.
module pos_oneshot (
  input  logic s_axi_clk,
  input  logic s_axi_reset,
  input  logic level,
  output logic pulse
);

  logic level_q;

  always_ff @(posedge s_axi_clk) begin
    if (s_axi_reset) level_q <= 1'b0;
    else             level_q <= level;
  end

  assign pulse = level & ~level_q;

endmodule

// File: rtl/ch_capture.sv
// Channel capture controller: samples ch_in on sample_tick, packs samples
// LSB-first into DATA_WIDTH-bit words and writes them over a start..stop window.
module ch_capture
  import ch_unit_pkg::*;
#(
  parameter int N_ADDR_BITS = 20,
  parameter int MEM_DEPTH   = 1048576,
  parameter int DATA_WIDTH  = 1
) (
  input  logic                   s_axi_clk,
  input  logic                   s_axi_reset,
  input  logic                   sample_tick,
  input  logic                   ch_in,
  input  logic                   capture_en,
  input  logic                   trig_mode,
  input  logic                   loop_capture,
  input  logic                   write_addr,
  input  logic [N_ADDR_BITS-1:0] set_ram_addr,
  input  logic                   write_stop_addr,
  input  logic [N_ADDR_BITS-1:0] stop_addr,
  output logic [N_ADDR_BITS-1:0] ram_addr,
  output logic [DATA_WIDTH-1:0]  ram_din,
  output logic                   wen,
  output logic                   capture_done,
  output logic                   wrapped,
  output logic [N_ADDR_BITS:0]   words_written
);

  localparam int CNT_W = $clog2(DATA_WIDTH + 1);
  localparam logic [N_ADDR_BITS-1:0] STOP_RST = N_ADDR_BITS'(MEM_DEPTH - 1);
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(DATA_WIDTH - 1);

  logic                   ch_meta_p0;
  logic                   ch_sync_p1;
  logic                   prev_sample;
  logic                   addr_load;
  logic                   stop_load;
  ch_state_t              state;
  logic [N_ADDR_BITS-1:0] start_reg;
  logic [N_ADDR_BITS-1:0] stop_reg;
  logic [CNT_W-1:0]       pack_cnt;
  logic [DATA_WIDTH-1:0]  pack_sr;
  logic [DATA_WIDTH-1:0]  pack_word;
  logic [DATA_WIDTH-1:0]  sample_vec;
  logic                   edge_seen;
  logic                   at_stop;
  logic                   last_write;
  logic                   sample_take;
  logic                   word_done;

  pos_oneshot u_addr_edge (
    .s_axi_clk   (s_axi_clk),
    .s_axi_reset (s_axi_reset),
    .level       (write_addr),
    .pulse       (addr_load)
  );

  pos_oneshot u_stop_edge (
    .s_axi_clk   (s_axi_clk),
    .s_axi_reset (s_axi_reset),
    .level       (write_stop_addr),
    .pulse       (stop_load)
  );

  // Stage p0/p1: two-flop synchronizer for the asynchronous channel input
  always_ff @(posedge s_axi_clk) begin
    if (s_axi_reset) begin
      ch_meta_p0  <= 1'b0;
      ch_sync_p1  <= 1'b0;
      prev_sample <= 1'b0;
    end else begin
      ch_meta_p0 <= ch_in;
      ch_sync_p1 <= ch_meta_p0;
      if (sample_tick) prev_sample <= ch_sync_p1;
    end
  end

  always_ff @(posedge s_axi_clk) begin
    if (s_axi_reset)    stop_reg <= STOP_RST;
    else if (stop_load) stop_reg <= stop_addr;
  end

  always_comb begin
    sample_vec    = '0;
    sample_vec[0] = ch_sync_p1;
    pack_word     = ((pack_cnt == '0) ? '0 : pack_sr) | (sample_vec << pack_cnt);
  end

  // The word that hits the stop address in non-loop mode ends the run, so a
  // tick landing in that same cycle must not start another word.
  assign edge_seen   = sample_tick & ch_sync_p1 & ~prev_sample;
  assign at_stop     = (ram_addr == stop_reg);
  assign last_write  = wen & at_stop & ~loop_capture;
  assign sample_take = capture_en & sample_tick &
                       (((state == ST_CAPTURE) & ~last_write) |
                        ((state == ST_ARMED) & edge_seen));
  assign word_done   = sample_take & (pack_cnt == LAST_CNT);

  // Stage p2: packer shift data, unreset
  always_ff @(posedge s_axi_clk) begin
    if (sample_take) pack_sr <= pack_word;
  end

  always_ff @(posedge s_axi_clk) begin
    if (s_axi_reset) begin
      state         <= ST_IDLE;
      ram_addr      <= '0;
      ram_din       <= '0;
      wen           <= 1'b0;
      capture_done  <= 1'b0;
      wrapped       <= 1'b0;
      words_written <= '0;
      start_reg     <= '0;
      pack_cnt      <= '0;
    end else begin
      wen <= 1'b0;
      if (wen && (words_written != '1))
        words_written <= words_written + (N_ADDR_BITS + 1)'(1);

      if (sample_take) begin
        if (word_done) begin
          pack_cnt <= '0;
          wen      <= 1'b1;
          ram_din  <= pack_word;
        end else begin
          pack_cnt <= pack_cnt + CNT_W'(1);
        end
      end

      if (addr_load && ((state == ST_IDLE) || (state == ST_DONE))) begin
        start_reg <= set_ram_addr;
        ram_addr  <= set_ram_addr;
      end

      case (state)
        ST_IDLE: begin
          if (capture_en) begin
            state         <= (trig_mode == TRIG_EDGE) ? ST_ARMED : ST_CAPTURE;
            pack_cnt      <= '0;
            words_written <= '0;
            wrapped       <= 1'b0;
            capture_done  <= 1'b0;
            ram_addr      <= start_reg;
          end
        end
        ST_ARMED: begin
          if (!capture_en)    state <= ST_IDLE;
          else if (edge_seen) state <= ST_CAPTURE;
        end
        ST_CAPTURE: begin
          if (!capture_en) begin
            state    <= ST_IDLE;
            pack_cnt <= '0;
          end else if (wen) begin
            if (at_stop) begin
              if (loop_capture) begin
                ram_addr <= start_reg;
                wrapped  <= 1'b1;
              end else begin
                state        <= ST_DONE;
                capture_done <= 1'b1;
              end
            end else begin
              ram_addr <= ram_addr + N_ADDR_BITS'(1);
            end
          end
        end
        ST_DONE: begin
          if (!capture_en) begin
            state        <= ST_IDLE;
            capture_done <= 1'b0;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_ch_capture.sv
// Scoreboard bench for ch_capture: three instances (1-, 4- and 8-bit words)
// share stimulus; expected RAM writes are queued per instance and checked by monitors.
module tb_ch_capture;
  import ch_unit_pkg::*;

  localparam int NA = 8;
  localparam int MD = 256;

  typedef struct packed {
    logic [7:0] addr;
    logic [7:0] data;
  } wr_t;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          sample_tick = 1'b0;
  logic          ch_in = 1'b0;
  logic          capture_en = 1'b0;
  logic          trig_mode = 1'b0;
  logic          loop_capture = 1'b0;
  logic          write_addr = 1'b0;
  logic [NA-1:0] set_ram_addr = '0;
  logic          write_stop_addr = 1'b0;
  logic [NA-1:0] stop_addr = '0;

  logic [NA-1:0] addr1, addr4, addr8;
  logic [0:0]    din1;
  logic [3:0]    din4;
  logic [7:0]    din8;
  logic          wen1, wen4, wen8;
  logic          done1, done4, done8;
  logic          wrap1, wrap4, wrap8;
  logic [NA:0]   ww1, ww4, ww8;

  wr_t q1[$];
  wr_t q4[$];
  wr_t q8[$];

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  ch_capture #(.N_ADDR_BITS(NA), .MEM_DEPTH(MD), .DATA_WIDTH(1)) dut1 (
    .s_axi_clk(clk), .s_axi_reset(rst), .sample_tick(sample_tick), .ch_in(ch_in),
    .capture_en(capture_en), .trig_mode(trig_mode), .loop_capture(loop_capture),
    .write_addr(write_addr), .set_ram_addr(set_ram_addr),
    .write_stop_addr(write_stop_addr), .stop_addr(stop_addr),
    .ram_addr(addr1), .ram_din(din1), .wen(wen1), .capture_done(done1),
    .wrapped(wrap1), .words_written(ww1));

  ch_capture #(.N_ADDR_BITS(NA), .MEM_DEPTH(MD), .DATA_WIDTH(4)) dut4 (
    .s_axi_clk(clk), .s_axi_reset(rst), .sample_tick(sample_tick), .ch_in(ch_in),
    .capture_en(capture_en), .trig_mode(trig_mode), .loop_capture(loop_capture),
    .write_addr(write_addr), .set_ram_addr(set_ram_addr),
    .write_stop_addr(write_stop_addr), .stop_addr(stop_addr),
    .ram_addr(addr4), .ram_din(din4), .wen(wen4), .capture_done(done4),
    .wrapped(wrap4), .words_written(ww4));

  ch_capture #(.N_ADDR_BITS(NA), .MEM_DEPTH(MD), .DATA_WIDTH(8)) dut8 (
    .s_axi_clk(clk), .s_axi_reset(rst), .sample_tick(sample_tick), .ch_in(ch_in),
    .capture_en(capture_en), .trig_mode(trig_mode), .loop_capture(loop_capture),
    .write_addr(write_addr), .set_ram_addr(set_ram_addr),
    .write_stop_addr(write_stop_addr), .stop_addr(stop_addr),
    .ram_addr(addr8), .ram_din(din8), .wen(wen8), .capture_done(done8),
    .wrapped(wrap8), .words_written(ww8));

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic cmp_write(input string name, input int a, input int d, input wr_t e);
    checks++;
    if (a != int'(e.addr) || d != int'(e.data)) begin
      errors++;
      $display("FAIL %s: got addr=0x%0h data=0x%0h, expected addr=0x%0h data=0x%0h",
               name, a, d, e.addr, e.data);
    end
  endtask

  task automatic no_write(input string name, input int a, input int d);
    checks++;
    errors++;
    $display("FAIL %s: unexpected write addr=0x%0h data=0x%0h, expected none", name, a, d);
  endtask

  // Monitors: one per instance, pop the oldest expected write on every wen.
  always @(negedge clk) begin
    wr_t e1;
    if (!rst && wen1) begin
      if (q1.size() == 0) no_write("dut1_write", int'(addr1), int'(din1));
      else begin e1 = q1.pop_front(); cmp_write("dut1_write", int'(addr1), int'(din1), e1); end
    end
  end

  always @(negedge clk) begin
    wr_t e4;
    if (!rst && wen4) begin
      if (q4.size() == 0) no_write("dut4_write", int'(addr4), int'(din4));
      else begin e4 = q4.pop_front(); cmp_write("dut4_write", int'(addr4), int'(din4), e4); end
    end
  end

  always @(negedge clk) begin
    wr_t e8;
    if (!rst && wen8) begin
      if (q8.size() == 0) no_write("dut8_write", int'(addr8), int'(din8));
      else begin e8 = q8.pop_front(); cmp_write("dut8_write", int'(addr8), int'(din8), e8); end
    end
  end

  task automatic exp_w(input int which, input int a, input int d);
    wr_t e;
    e.addr = 8'(a);
    e.data = 8'(d);
    case (which)
      1:       q1.push_back(e);
      4:       q4.push_back(e);
      default: q8.push_back(e);
    endcase
  endtask

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Set ch_in, let it cross the synchronizer, then strobe one tick.
  task automatic send_bit(input logic b);
    ch_in = b;
    cyc(2);
    sample_tick = 1'b1;
    cyc(1);
    sample_tick = 1'b0;
  endtask

  task automatic load_start(input int a);
    set_ram_addr = NA'(a);
    write_addr = 1'b1;
    cyc(1);
    write_addr = 1'b0;
    cyc(1);
  endtask

  task automatic load_stop(input int a);
    stop_addr = NA'(a);
    write_stop_addr = 1'b1;
    cyc(1);
    write_stop_addr = 1'b0;
    cyc(1);
  endtask

  task automatic start_run(input logic trig);
    trig_mode = trig;
    capture_en = 1'b1;
    cyc(2);
  endtask

  task automatic stop_run();
    capture_en = 1'b0;
    cyc(2);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: bench still running at time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    cyc(3);
    chk("rst_addr1", int'(addr1), 0);
    chk("rst_din1", int'(din1), 0);
    chk("rst_wen1", int'(wen1), 0);
    chk("rst_done1", int'(done1), 0);
    chk("rst_wrap1", int'(wrap1), 0);
    chk("rst_ww1", int'(ww1), 0);
    rst = 1'b0;
    cyc(1);

    // Immediate trigger, window 0x10..0x13, bits 1,0,1,1
    load_start(8'h10);
    load_stop(8'h13);
    exp_w(1, 8'h10, 1); exp_w(1, 8'h11, 0); exp_w(1, 8'h12, 1); exp_w(1, 8'h13, 1);
    exp_w(4, 8'h10, 4'hD);
    start_run(TRIG_IMMEDIATE);
    send_bit(1'b1); send_bit(1'b0); send_bit(1'b1); send_bit(1'b1);
    cyc(2);
    chk("t1_done1", int'(done1), 1);
    chk("t1_ww1", int'(ww1), 4);
    chk("t1_addr1", int'(addr1), 8'h13);
    chk("t1_wen1_idle", int'(wen1), 0);
    chk("t1_done4", int'(done4), 0);
    chk("t1_ww4", int'(ww4), 1);
    chk("t1_addr4", int'(addr4), 8'h11);
    chk("t1_ww8", int'(ww8), 0);
    stop_run();
    chk("t1_done1_clear", int'(done1), 0);

    // Single-word window at 0, bits 1,0,0,0,0,0,0,1
    load_start(0);
    load_stop(0);
    exp_w(8, 0, 8'h81);
    exp_w(4, 0, 4'h1);
    exp_w(1, 0, 1);
    start_run(TRIG_IMMEDIATE);
    send_bit(1'b1); send_bit(1'b0); send_bit(1'b0); send_bit(1'b0);
    send_bit(1'b0); send_bit(1'b0); send_bit(1'b0); send_bit(1'b1);
    cyc(2);
    chk("t2_done8", int'(done8), 1);
    chk("t2_ww8", int'(ww8), 1);
    chk("t2_addr8", int'(addr8), 0);
    chk("t2_done4", int'(done4), 1);
    chk("t2_ww1", int'(ww1), 1);
    stop_run();

    // Ring buffer 5..6, five samples
    loop_capture = 1'b1;
    load_start(5);
    load_stop(6);
    exp_w(1, 5, 1); exp_w(1, 6, 0); exp_w(1, 5, 1); exp_w(1, 6, 1); exp_w(1, 5, 0);
    exp_w(4, 5, 4'hD);
    start_run(TRIG_IMMEDIATE);
    send_bit(1'b1);
    chk("t3_wrap1_early", int'(wrap1), 0);
    send_bit(1'b0); send_bit(1'b1);
    chk("t3_wrap1_third", int'(wrap1), 1);
    send_bit(1'b1); send_bit(1'b0);
    cyc(2);
    chk("t3_wrap1", int'(wrap1), 1);
    chk("t3_done1", int'(done1), 0);
    chk("t3_ww1", int'(ww1), 5);
    chk("t3_addr1", int'(addr1), 6);
    chk("t3_wrap4", int'(wrap4), 0);
    chk("t3_ww4", int'(ww4), 1);
    stop_run();
    loop_capture = 1'b0;

    // Edge trigger: prime previous sample at 1, then 1,0 arm without writes, 1 fires
    load_start(8'h20);
    load_stop(8'h23);
    send_bit(1'b1);
    start_run(TRIG_EDGE);
    send_bit(1'b1); send_bit(1'b0);
    cyc(2);
    chk("t4_ww1_armed", int'(ww1), 0);
    chk("t4_addr1_armed", int'(addr1), 8'h20);
    exp_w(1, 8'h20, 1); exp_w(1, 8'h21, 0); exp_w(1, 8'h22, 1); exp_w(1, 8'h23, 1);
    exp_w(4, 8'h20, 4'hD);
    send_bit(1'b1); send_bit(1'b0); send_bit(1'b1); send_bit(1'b1);
    cyc(2);
    chk("t4_done1", int'(done1), 1);
    chk("t4_ww1", int'(ww1), 4);
    chk("t4_ww4", int'(ww4), 1);
    chk("t4_ww8", int'(ww8), 0);
    stop_run();

    // Abort mid-word (two of four samples), then restart from the start address
    load_start(8'h30);
    load_stop(8'h3F);
    exp_w(1, 8'h30, 1); exp_w(1, 8'h31, 1);
    start_run(TRIG_IMMEDIATE);
    send_bit(1'b1); send_bit(1'b1);
    stop_run();
    chk("t5_state4", int'(dut4.state), int'(ST_IDLE));
    chk("t5_wen4", int'(wen4), 0);
    chk("t5_ww4_abort", int'(ww4), 0);
    start_run(TRIG_IMMEDIATE);
    chk("t5_ww4_restart", int'(ww4), 0);
    chk("t5_addr4_restart", int'(addr4), 8'h30);
    chk("t5_ww1_restart", int'(ww1), 0);
    exp_w(1, 8'h30, 0); exp_w(1, 8'h31, 1); exp_w(1, 8'h32, 1); exp_w(1, 8'h33, 0);
    exp_w(4, 8'h30, 4'h6);
    send_bit(1'b0); send_bit(1'b1); send_bit(1'b1); send_bit(1'b0);
    cyc(2);
    chk("t5_ww4", int'(ww4), 1);
    chk("t5_ww1", int'(ww1), 4);

    // Synchronous reset in the middle of a capture
    rst = 1'b1;
    capture_en = 1'b0;
    cyc(1);
    rst = 1'b0;
    chk("t6_addr1", int'(addr1), 0);
    chk("t6_din1", int'(din1), 0);
    chk("t6_wen1", int'(wen1), 0);
    chk("t6_done1", int'(done1), 0);
    chk("t6_wrap1", int'(wrap1), 0);
    chk("t6_ww1", int'(ww1), 0);
    chk("t6_addr4", int'(addr4), 0);
    chk("t6_din4", int'(din4), 0);
    chk("t6_stop1", int'(dut1.stop_reg), MD - 1);
    cyc(1);
    load_start(254);
    exp_w(1, 254, 1); exp_w(1, 255, 0);
    start_run(TRIG_IMMEDIATE);
    send_bit(1'b1); send_bit(1'b0);
    cyc(2);
    chk("t6_done1_stop_rst", int'(done1), 1);
    chk("t6_ww1_stop_rst", int'(ww1), 2);
    stop_run();

    // Start above stop: address wraps through zero
    load_start(255);
    load_stop(0);
    exp_w(1, 255, 1); exp_w(1, 0, 1);
    start_run(TRIG_IMMEDIATE);
    send_bit(1'b1); send_bit(1'b1);
    cyc(2);
    chk("t7_done1", int'(done1), 1);
    chk("t7_addr1", int'(addr1), 0);
    chk("t7_ww1", int'(ww1), 2);
    stop_run();

    cyc(2);
    chk("q1_drained", q1.size(), 0);
    chk("q4_drained", q4.size(), 0);
    chk("q8_drained", q8.size(), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
